// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: receives a COUNT / data / CSUM frame, writes the data words into
// instruction memory and holds the CPU in reset until the checksum matches.
module imem_boot_loader #(
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [31:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [1:0]  byte_idx;
    logic [23:0] byte_buf;
    logic [31:0] count;
    logic [31:0] sum;

    logic              accept;
    logic              field_done;
    logic [31:0]       field;
    logic              last_word;
    logic [ADDR_W-1:0] word_addr;

    assign accept     = s_valid && s_ready;
    assign field_done = accept && (byte_idx == 2'd3);
    assign field      = {s_data, byte_buf};
    // words_loaded doubles as the word index k of the word being assembled.
    assign last_word  = (words_loaded == count - 32'd1);
    assign word_addr  = BASE_ADDR + ADDR_W'(words_loaded << 2);

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state <= S_HDR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: next_state gets a default first so no branch leaves it unassigned (no latch).
        next_state = state;
        case (state)
            S_HDR: begin
                if (field_done) begin
                    if (field > DEPTH_WORDS) next_state = S_ERR;
                    else if (field == 32'd0) next_state = S_CSUM;
                    else                     next_state = S_DATA;
                end
            end
            S_DATA: if (field_done && last_word) next_state = S_CSUM;
            S_CSUM: if (field_done) next_state = (field == sum) ? S_RUN : S_ERR;
            S_RUN,
            S_ERR:  if (reload) next_state = S_HDR;
            default: next_state = S_HDR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            byte_idx     <= '0;
            byte_buf     <= '0;
            count        <= '0;
            sum          <= '0;
            words_loaded <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= '0;
            s_ready      <= 1'b1;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            imem_we    <= 1'b0;
            // Status flops are loaded from next_state so they track the state register exactly.
            s_ready    <= (next_state == S_HDR) || (next_state == S_DATA) || (next_state == S_CSUM);
            cpu_hold   <= (next_state != S_RUN);
            load_done  <= (next_state == S_RUN);
            load_error <= (next_state == S_ERR);

            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx != 2'd3) byte_buf[8*byte_idx +: 8] <= s_data;
            end

            if (field_done && state == S_HDR) count <= field;

            if (field_done && state == S_DATA) begin
                imem_we      <= 1'b1;
                imem_addr    <= word_addr;
                imem_wdata   <= field;
                sum          <= sum + field;
                words_loaded <= words_loaded + 32'd1;
            end

            if ((state == S_RUN || state == S_ERR) && reload) begin
                byte_idx     <= '0;
                count        <= '0;
                sum          <= '0;
                words_loaded <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected imem writes are queued as words are sent
// and popped by a monitor when imem_we pulses.
module tb_imem_boot_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [31:0] words_loaded;

    imem_boot_loader #(
        .DEPTH_WORDS(1024),
        .ADDR_W     (32),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .reload      (reload),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_error  (load_error),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          total = 0;
    int          bad = 0;
    int          we_count = 0;
    logic        prev_we = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            wr_t w;
            we_count++;
            check("we_one_cycle", 32'(prev_we), 32'd0);
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("wr_addr", imem_addr, w.addr);
                check("wr_data", imem_wdata, w.data);
            end
        end
        prev_we = imem_we;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            int g = $urandom_range(2, 0);
            s_valid = 1'b0;
            repeat (g) @(negedge clock);
        end
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (s_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(s_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gaps);
    endtask

    task automatic send_data_word(input logic [31:0] w, input int idx, input bit gaps);
        wr_t e;
        e.addr = 32'(idx) * 32'd4;
        e.data = w;
        exp_q.push_back(e);
        send_word(w, gaps);
    endtask

    function automatic logic [31:0] img_sum();
        logic [31:0] s = '0;
        foreach (img[i]) s += img[i];
        return s;
    endfunction

    task automatic send_image(input logic [31:0] csum_xor, input bit gaps);
        send_word(32'(img.size()), gaps);
        foreach (img[i]) send_data_word(img[i], i, gaps);
        send_word(img_sum() ^ csum_xor, gaps);
    endtask

    task automatic pulse_reload();
        @(negedge clock);
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic settle();
        repeat (2) @(negedge clock);
    endtask

    task automatic check_hdr(input string tag);
        check({tag, "_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_err"}, 32'(load_error), 32'd0);
        check({tag, "_words"}, words_loaded, 32'd0);
    endtask

    task automatic check_end(input string tag, input bit ok, input int n, input int we_base);
        settle();
        check({tag, "_done"}, 32'(load_done), 32'(ok));
        check({tag, "_err"}, 32'(load_error), 32'(!ok));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(!ok));
        check({tag, "_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_words"}, words_loaded, 32'(n));
        check({tag, "_writes"}, 32'(we_count - we_base), 32'(n));
        check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int base;
        logic [31:0] prog[16];

        repeat (2) @(negedge clock);
        reset = 1'b1;
        check_hdr("rst");
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);

        // 1: 16-word program, good checksum, no gaps.
        prog[0] = 32'h00A00093;
        prog[1] = 32'h00500113;
        prog[2] = 32'h002081B3;
        for (int i = 3; i < 16; i++) prog[i] = 32'h00000013;
        img.delete();
        foreach (prog[i]) img.push_back(prog[i]);
        base = we_count;
        send_word(32'd16, 1'b0);
        check("t1_hold_mid", 32'(cpu_hold), 32'd1);
        foreach (img[i]) send_data_word(img[i], i, 1'b0);
        send_word(img_sum(), 1'b0);
        check("t1_done_edge", 32'(load_done), 32'd1);
        check("t1_hold_edge", 32'(cpu_hold), 32'd0);
        check_end("t1", 1'b1, 16, base);
        pulse_reload();
        check_hdr("t1_reload");

        // 2: same image, checksum LSB flipped.
        base = we_count;
        send_image(32'd1, 1'b0);
        check_end("t2", 1'b0, 16, base);
        pulse_reload();
        check_hdr("t2_reload");

        // 3: header just over capacity, then bytes that must be refused.
        base = we_count;
        send_word(32'd1025, 1'b0);
        check("t3_err", 32'(load_error), 32'd1);
        check("t3_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        repeat (5) @(negedge clock);
        check("t3_still_refused", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        check("t3_writes", 32'(we_count - base), 32'd0);
        check("t3_hold", 32'(cpu_hold), 32'd1);
        pulse_reload();
        check_hdr("t3_reload");

        // Header exactly at capacity is accepted; abandon the frame with reset.
        send_word(32'd1024, 1'b0);
        check("cap_err", 32'(load_error), 32'd0);
        check("cap_ready", 32'(s_ready), 32'd1);
        pulse_reset();
        check_hdr("cap_reset");

        // 4: empty images.
        img.delete();
        base = we_count;
        send_image(32'd0, 1'b0);
        check_end("t4a", 1'b1, 0, base);
        pulse_reload();
        base = we_count;
        send_image(32'd1, 1'b0);
        check_end("t4b", 1'b0, 0, base);
        pulse_reload();
        check_hdr("t4_reload");

        // 5: 4 random words with valid gaps; a reload mid-frame must be ignored.
        img.delete();
        for (int i = 0; i < 4; i++) img.push_back($urandom);
        base = we_count;
        send_word(32'd4, 1'b1);
        send_data_word(img[0], 0, 1'b1);
        send_data_word(img[1], 1, 1'b1);
        pulse_reload();
        check("t5_reload_ignored_words", words_loaded, 32'd2);
        check("t5_reload_ignored_ready", 32'(s_ready), 32'd1);
        send_data_word(img[2], 2, 1'b1);
        send_data_word(img[3], 3, 1'b1);
        send_word(img_sum(), 1'b1);
        check_end("t5", 1'b1, 4, base);
        pulse_reload();

        // 6: reset after 2 of 3 words, full reload, reload, then a second image.
        img.delete();
        for (int i = 0; i < 3; i++) img.push_back(32'h1000_0000 + 32'(i) * 32'h111);
        send_word(32'd3, 1'b0);
        send_data_word(img[0], 0, 1'b0);
        send_data_word(img[1], 1, 1'b0);
        settle();
        check("t6_partial_words", words_loaded, 32'd2);
        pulse_reset();
        check_hdr("t6_reset");
        check("t6_reset_addr", imem_addr, 32'h0);
        base = we_count;
        send_image(32'd0, 1'b0);
        check_end("t6a", 1'b1, 3, base);
        pulse_reload();
        check_hdr("t6_reload");
        img.delete();
        img.push_back(32'hDEAD_BEEF);
        img.push_back(32'h2000_0001);
        base = we_count;
        send_image(32'd0, 1'b0);
        check_end("t6b", 1'b1, 2, base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
